// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the unified memory-port arbiter.
//   arb_state_t : access sequencer phases (IDLE -> ISSUE -> WAIT -> RESP)
//   arb_owner_t : which requester owns the access in flight
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and data access (MEM). Each access runs IDLE -> ISSUE -> WAIT -> RESP.
// Data wins contention unless fetch has lost STARVE_MAX grants in a row.
// A flush kills an in-flight fetch (the memory access still runs to completion).
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   if_req/if_addr       : fetch request (held until if_valid or flush)
//   if_rdata/if_valid    : fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : data request (held until d_valid)
//   d_rdata/d_valid      : load data, one-cycle completion pulse
//   flush                : pipeline redirect
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata            : memory read data, MEM_LAT cycles after mem_en
//   stall_if/stall_mem   : per-stage hold, request & ~valid
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              kill_q, kill_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_vld_q, if_vld_d;
    logic              d_vld_q, d_vld_d;

    logic fetch_win;
    logic if_killed;

    // Fetch only beats a concurrent data request once it has been starved.
    assign fetch_win = if_req & (~d_req | (starve_q == STARVE_LIM));
    // A flush arriving in the capture cycle itself must also kill the fetch.
    assign if_killed = kill_q | flush;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        kill_d      = kill_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_vld_d    = 1'b0;
        d_vld_d     = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (if_req | d_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (fetch_win) begin
                        owner_d    = OWN_IF;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr;
                        starve_d   = '0;
                    end else begin
                        owner_d     = OWN_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (if_req && starve_q != CNT_MAX)
                            starve_d = starve_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                wait_d  = WAIT_INIT;
                state_d = WAIT;
                if (owner_q == OWN_IF && flush)
                    kill_d = 1'b1;
            end
            WAIT: begin
                if (owner_q == OWN_IF && flush)
                    kill_d = 1'b1;
                if (wait_q == '0) begin
                    state_d = RESP;
                    // Valids are registered here so they show up in RESP.
                    if (owner_q == OWN_IF) begin
                        if (!if_killed) begin
                            if_rdata_d = mem_rdata;
                            if_vld_d   = 1'b1;
                        end
                    end else begin
                        if (!mem_we_q)
                            d_rdata_d = mem_rdata;
                        d_vld_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            wait_q      <= '0;
            kill_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_vld_q    <= 1'b0;
            d_vld_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            kill_q      <= kill_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_vld_q    <= if_vld_d;
            d_vld_q     <= d_vld_d;
        end
    end

    // mem_we holds the latched direction; it only matters while mem_en is high.
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    // A flush during RESP still drops the fetch completion.
    assign if_valid  = if_vld_q & ~flush;
    assign d_valid   = d_vld_q;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, d_req, d_we, flush;
    logic [ADDR_W-1:0] if_addr, d_addr;
    logic [DATA_W-1:0] d_wdata, if_rdata, d_rdata;
    logic              if_valid, d_valid;
    logic              mem_en, mem_we, stall_if, stall_mem;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // Power-on memory contents for words never written.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        case (a)
            7'd5:    return 32'hDEADBEEF;
            7'd10:   return 32'hA0A0A0A0;
            7'd12:   return 32'h11111111;
            7'd13:   return 32'h22222222;
            7'd20:   return 32'hD0D0D0D0;
            default: return {25'h0, a};
        endcase
    endfunction

    logic [DATA_W-1:0] mem   [0:127];
    logic              wr    [0:127];
    logic [DATA_W-1:0] rpipe [0:MEM_LAT-1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) wr[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
        rpipe[0] <= (mem_en && !mem_we) ? (wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr)) : 32'h0;
        for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[MEM_LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One data access starting in an IDLE cycle; optional flush in the WAIT cycle.
    task automatic d_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                            input logic fl);
        cyc(); d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; #1;
        chk("d_stall_t0", stall_mem, 1);
        chk("d_en_t0", mem_en, 0);
        cyc(); #1;
        chk("d_en_t1", mem_en, 1);
        chk("d_we_t1", mem_we, we);
        chk("d_addr_t1", mem_addr, addr);
        if (we) chk("d_wdata_t1", mem_wdata, wd);
        cyc(); flush = fl; #1;
        chk("d_en_t2", mem_en, 0);
        chk("d_stall_t2", stall_mem, 1);
        cyc(); flush = 1'b0; #1;
        chk("d_valid_t3", d_valid, 0);
        cyc(); #1;
        chk("d_valid_t4", d_valid, 1);
        chk("d_rdata_t4", d_rdata, exp_rd);
        chk("d_stall_t4", stall_mem, 0);
        cyc(); d_req = 1'b0; #1;
        chk("d_valid_t5", d_valid, 0);
        chk("d_rdata_hold", d_rdata, exp_rd);
    endtask

    initial begin
        int c, n;
        logic exp_f;

        reset = 1'b1; if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; flush = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        cyc(); cyc(); #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_stall_mem", stall_mem, 1);
        chk("rst_stall_if", stall_if, 0);
        cyc(); d_req = 1'b0; reset = 1'b0;

        // Lone load, store (flush must not disturb it), read-back.
        d_access(1'b0, 7'd5, 32'h0, 32'hDEADBEEF, 1'b0);
        d_access(1'b1, 7'd3, 32'h12345678, 32'hDEADBEEF, 1'b1);
        d_access(1'b0, 7'd3, 32'h0, 32'h12345678, 1'b0);

        // Contention: D D D D IF, repeated, each grant 5 cycles apart.
        cyc(); if_req = 1'b1; if_addr = 7'd10; d_req = 1'b1; d_we = 1'b0; d_addr = 7'd20;
        c = 0; n = 0;
        while (n < 10 && c < 80) begin
            #1;
            if (c == 0) begin
                chk("cont_stall_if", stall_if, 1);
                chk("cont_stall_mem", stall_mem, 1);
            end
            if (if_valid || d_valid) begin
                n++;
                exp_f = (n % 5 == 0);
                chk("cont_owner", {if_valid, d_valid}, exp_f ? 2'b10 : 2'b01);
                chk("cont_time", c, 4 + 5 * (n - 1));
                if (exp_f) chk("cont_if_rdata", if_rdata, 32'hA0A0A0A0);
                else       chk("cont_d_rdata", d_rdata, 32'hD0D0D0D0);
            end
            if (n < 10) begin
                cyc(); c++;
            end
        end
        if (n < 10) chk("cont_timeout", n, 10);
        cyc(); if_req = 1'b0; d_req = 1'b0;

        // Flush kills fetch to word 12; fetch to 13 (with flush in its IDLE) completes.
        cyc(); if_req = 1'b1; if_addr = 7'd12; #1;
        chk("fl_stall_t0", stall_if, 1);
        cyc(); #1;
        chk("fl_en_t1", mem_en, 1);
        chk("fl_addr_t1", mem_addr, 12);
        cyc(); flush = 1'b1; #1;
        chk("fl_valid_t2", if_valid, 0);
        cyc(); flush = 1'b0; if_req = 1'b0; #1;
        chk("fl_valid_t3", if_valid, 0);
        cyc(); #1;
        chk("fl_valid_t4", if_valid, 0);
        chk("fl_rdata_hold", if_rdata, 32'hA0A0A0A0);
        cyc(); if_req = 1'b1; if_addr = 7'd13; flush = 1'b1; #1;
        chk("fl2_valid_t0", if_valid, 0);
        cyc(); flush = 1'b0; #1;
        chk("fl2_en_t1", mem_en, 1);
        chk("fl2_addr_t1", mem_addr, 13);
        cyc(); cyc(); cyc(); #1;
        chk("fl2_valid_t4", if_valid, 1);
        chk("fl2_rdata", if_rdata, 32'h22222222);
        chk("fl2_stall_t4", stall_if, 0);
        cyc(); if_req = 1'b0; #1;
        chk("fl2_valid_t5", if_valid, 0);

        // Reset while in WAIT abandons the load; a fresh load then completes.
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 7'd5; d_wdata = 32'hCAFE0000;
        cyc(); #1;
        chk("rw_en_t1", mem_en, 1);
        chk("rw_wdata_t1", mem_wdata, 32'hCAFE0000);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; d_addr = 7'd20; #1;
        chk("rw_mem_en", mem_en, 0);
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_mem_wdata", mem_wdata, 0);
        chk("rw_d_rdata", d_rdata, 0);
        chk("rw_if_rdata", if_rdata, 0);
        chk("rw_d_valid", d_valid, 0);
        chk("rw_stall_mem", stall_mem, 1);
        cyc(); #1;
        chk("rw2_en_t1", mem_en, 1);
        chk("rw2_addr_t1", mem_addr, 20);
        chk("rw2_valid_t1", d_valid, 0);
        cyc(); #1;
        chk("rw2_valid_t2", d_valid, 0);
        cyc(); #1;
        chk("rw2_valid_t3", d_valid, 0);
        cyc(); #1;
        chk("rw2_valid_t4", d_valid, 1);
        chk("rw2_rdata", d_rdata, 32'hD0D0D0D0);
        cyc(); d_req = 1'b0; #1;
        chk("rw2_valid_t5", d_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
